// File: rtl/div_share_ctrl.sv
// Round-robin arbiter sharing one fixed-point divider among four requesters.
// Latches the winner's operands, sequences load/wait/response and aborts a hung divider on timeout.
module div_share_ctrl #(
   parameter int N       = 16,
   parameter int TIMEOUT = 31
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [3:0]     req,
   input  logic [4*N-1:0] dividend_in,
   input  logic [4*N-1:0] divisor_in,
   output logic [3:0]     grant,
   output logic [3:0]     rsp_valid,
   output logic [N-1:0]   rsp_q,
   output logic [1:0]     rsp_status,
   output logic           div_load,
   output logic [N-1:0]   div_dividend,
   output logic [N-1:0]   div_divisor,
   input  logic [N-1:0]   div_q,
   input  logic           div_ready,
   input  logic           div_ovf,
   input  logic           div_dbz
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, LOAD, WAIT, RESP} state_t;

   state_t          state, state_nx;
   logic [1:0]      ptr, ptr_nx;
   logic [CW-1:0]   cnt, cnt_nx;
   logic [3:0]      grant_nx, rsp_valid_nx;
   logic [N-1:0]    rsp_q_nx, dvd_nx, dvs_nx;
   logic [1:0]      status_nx;
   logic            load_nx;
   logic [1:0]      win, idx;
   logic            found;

   // First requester at or above the pointer, wrapping modulo 4
   always_comb begin
      win   = '0;
      idx   = '0;
      found = 1'b0;
      for (int unsigned k = 0; k < 4; k++) begin
         idx = ptr + 2'(k);
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   always_comb begin
      state_nx     = state;
      ptr_nx       = ptr;
      cnt_nx       = cnt;
      grant_nx     = grant;
      rsp_valid_nx = '0;
      rsp_q_nx     = rsp_q;
      status_nx    = rsp_status;
      load_nx      = 1'b0;
      dvd_nx       = div_dividend;
      dvs_nx       = div_divisor;
      case (state)
         IDLE: begin
            if (found) begin
               grant_nx = 4'b0001 << win;
               dvd_nx   = dividend_in[win*N +: N];
               dvs_nx   = divisor_in[win*N +: N];
               load_nx  = 1'b1;
               ptr_nx   = win + 2'd1;
               state_nx = LOAD;
            end
         end
         LOAD: begin
            cnt_nx   = '0;
            state_nx = WAIT;
         end
         WAIT: begin
            if (div_ready) begin
               rsp_q_nx     = div_q;
               status_nx    = div_dbz ? 2'b10 : (div_ovf ? 2'b01 : 2'b00);
               rsp_valid_nx = grant;
               state_nx     = RESP;
            end else if (cnt == CW'(TIMEOUT)) begin
               rsp_q_nx     = '0;
               status_nx    = 2'b11;
               rsp_valid_nx = grant;
               state_nx     = RESP;
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         RESP: begin
            grant_nx = '0;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // All outputs are registered so div_load lands exactly in the LOAD cycle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         ptr          <= '0;
         cnt          <= '0;
         grant        <= '0;
         rsp_valid    <= '0;
         rsp_q        <= '0;
         rsp_status   <= '0;
         div_load     <= 1'b0;
         div_dividend <= '0;
         div_divisor  <= '0;
      end else begin
         state        <= state_nx;
         ptr          <= ptr_nx;
         cnt          <= cnt_nx;
         grant        <= grant_nx;
         rsp_valid    <= rsp_valid_nx;
         rsp_q        <= rsp_q_nx;
         rsp_status   <= status_nx;
         div_load     <= load_nx;
         div_dividend <= dvd_nx;
         div_divisor  <= dvs_nx;
      end
   end

endmodule

// File: tb/tb_div_share_ctrl.sv
// Self-checking bench for div_share_ctrl: directed scenarios plus randomized request mixes
// against a transaction-level model of arbitration order, latency and result.
module tb_div_share_ctrl;
   localparam int N  = 16;
   localparam int TO = 31;

   logic           clk = 1'b0;
   logic           reset = 1'b0;
   logic [3:0]     req = '0;
   logic [4*N-1:0] dividend_in = '0;
   logic [4*N-1:0] divisor_in = '0;
   logic [3:0]     grant, rsp_valid;
   logic [N-1:0]   rsp_q;
   logic [1:0]     rsp_status;
   logic           div_load;
   logic [N-1:0]   div_dividend, div_divisor;
   logic [N-1:0]   div_q = '0;
   logic           div_ready = 1'b0;
   logic           div_ovf = 1'b0;
   logic           div_dbz = 1'b0;

   int checks = 0;
   int errors = 0;
   int ptr_m  = 0;
   logic hang = 1'b0;
   logic force_ovf = 1'b0;
   logic [N-1:0] opa [4];
   logic [N-1:0] opb [4];

   always #5 clk = ~clk;

   div_share_ctrl #(.N(N), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .req(req),
      .dividend_in(dividend_in), .divisor_in(divisor_in),
      .grant(grant), .rsp_valid(rsp_valid), .rsp_q(rsp_q), .rsp_status(rsp_status),
      .div_load(div_load), .div_dividend(div_dividend), .div_divisor(div_divisor),
      .div_q(div_q), .div_ready(div_ready), .div_ovf(div_ovf), .div_dbz(div_dbz)
   );

   // Fixed-point quotient: value fields divided, dividend's scale kept; saturate on zero divisor
   function automatic logic [N-1:0] qref(input logic [N-1:0] a, input logic [N-1:0] b);
      int unsigned av, bv;
      av = 32'(a >> 3);
      bv = 32'(b >> 3);
      if (bv == 0) return '1;
      return N'((av / bv) << 3) | N'(a[2:0]);
   endfunction

   function automatic logic is_dbz(input logic [N-1:0] b);
      return (b >> 3) == '0;
   endfunction

   // Divider model: ready 16 edges after the load edge (1 for divide-by-zero), never when hung
   int dcnt = 0;
   logic [N-1:0] dq_pend = '0;
   always @(posedge clk) begin
      if (div_load) begin
         div_ready <= 1'b0;
         div_q     <= N'($urandom);
         dq_pend   <= qref(div_dividend, div_divisor);
         div_dbz   <= is_dbz(div_divisor);
         div_ovf   <= force_ovf;
         dcnt      <= hang ? 0 : (is_dbz(div_divisor) ? 1 : 16);
      end else if (dcnt > 0) begin
         dcnt <= dcnt - 1;
         if (dcnt == 1) begin
            div_ready <= 1'b1;
            div_q     <= dq_pend;
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int pick(input logic [3:0] r, input int p);
      for (int k = 0; k < 4; k++)
         if (r[(p + k) % 4]) return (p + k) % 4;
      return -1;
   endfunction

   task automatic set_req(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
      opa[i] = a;
      opb[i] = b;
      dividend_in[i*N +: N] = a;
      divisor_in[i*N +: N]  = b;
      req[i] = 1'b1;
   endtask

   // Called during the IDLE cycle in which req is sampled (cycle 0)
   task automatic do_op;
      int w, lat, cyc;
      logic [N-1:0] a, b, eq;
      logic [1:0] es;
      w = pick(req, ptr_m);
      chk("winner_exists", 32'(w >= 0), 32'd1);
      if (w < 0) return;
      a = opa[w];
      b = opb[w];
      if (hang) begin
         lat = 2 + TO + 1; eq = '0; es = 2'b11;
      end else if (is_dbz(b)) begin
         lat = 4; eq = qref(a, b); es = 2'b10;
      end else begin
         lat = 19; eq = qref(a, b); es = force_ovf ? 2'b01 : 2'b00;
      end
      tick;
      chk("grant_c1", 32'(grant), 32'(1) << w);
      chk("load_c1", 32'(div_load), 32'd1);
      chk("dividend_c1", 32'(div_dividend), 32'(a));
      chk("divisor_c1", 32'(div_divisor), 32'(b));
      dividend_in[w*N +: N] = N'($urandom);
      divisor_in[w*N +: N]  = N'($urandom);
      tick;
      chk("load_c2", 32'(div_load), 32'd0);
      chk("grant_c2", 32'(grant), 32'(1) << w);
      cyc = 2;
      while (rsp_valid == '0 && cyc < 45) begin
         tick;
         cyc++;
      end
      chk("rsp_cycle", 32'(cyc), 32'(lat));
      chk("rsp_valid", 32'(rsp_valid), 32'(1) << w);
      chk("rsp_q", 32'(rsp_q), 32'(eq));
      chk("rsp_status", 32'(rsp_status), 32'(es));
      chk("grant_resp", 32'(grant), 32'(1) << w);
      req[w] = 1'b0;
      ptr_m = (w + 1) % 4;
      tick;
      chk("valid_after", 32'(rsp_valid), 32'd0);
      chk("grant_after", 32'(grant), 32'd0);
      chk("q_held", 32'(rsp_q), 32'(eq));
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_grant"}, 32'(grant), 32'd0);
      chk({tag, "_valid"}, 32'(rsp_valid), 32'd0);
      chk({tag, "_q"}, 32'(rsp_q), 32'd0);
      chk({tag, "_status"}, 32'(rsp_status), 32'd0);
      chk({tag, "_load"}, 32'(div_load), 32'd0);
      chk({tag, "_dvd"}, 32'(div_dividend), 32'd0);
      chk({tag, "_dvs"}, 32'(div_divisor), 32'd0);
   endtask

   initial begin
      logic [N-1:0] ra, rb;
      #1;
      chk_zero("reset");
      #3 reset = 1'b1;
      tick;
      tick;
      chk("idle_grant", 32'(grant), 32'd0);

      set_req(0, 16'h0053, 16'h0013);
      do_op;
      chk("single_q", 32'(rsp_q), 32'h002B);

      set_req(2, 16'h00A1, 16'h0000);
      do_op;

      hang = 1'b1;
      set_req(3, 16'h0123, 16'h0021);
      do_op;
      hang = 1'b0;

      for (int i = 0; i < 4; i++) set_req(i, N'($urandom), N'($urandom_range(8, 16'hFFFF)));
      for (int i = 0; i < 4; i++) do_op;

      set_req(0, 16'h0400, 16'h0020);
      set_req(3, 16'h0333, 16'h0011);
      do_op;
      do_op;

      force_ovf = 1'b1;
      set_req(1, 16'h7FF8, 16'h0008);
      do_op;
      set_req(1, 16'h1234, 16'h0003);
      do_op;
      force_ovf = 1'b0;

      for (int n = 0; n < 14; n++) begin
         for (int i = 0; i < 4; i++) begin
            if (!req[i] && $urandom_range(0, 1) == 1) begin
               ra = N'($urandom);
               rb = N'($urandom);
               if ($urandom_range(0, 3) == 0) rb[N-1:3] = '0;
               set_req(i, ra, rb);
            end
         end
         if (req == '0) set_req(n % 4, N'($urandom), 16'h0019);
         force_ovf = 1'($urandom_range(0, 1));
         hang = ($urandom_range(0, 7) == 0);
         do_op;
         hang = 1'b0;
      end
      force_ovf = 1'b0;

      set_req(1, 16'h0643, 16'h0023);
      tick;
      for (int c = 2; c <= 10; c++) tick;
      #2 reset = 1'b0;
      #1;
      chk_zero("async");
      #1 reset = 1'b1;
      ptr_m = 0;
      do_op;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
